// File: rtl/execute_stage.sv
// EX stage of a 5-stage MIPS pipeline: operand select, ALU, branch-target add, dest select,
// an iterative shift-add multiplier that stalls upstream, and the EX/MEM output register.
module execute_stage #(
    parameter int MUL_EN   = 1,
    parameter int MUL_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic        regdst,
    input  logic        alusrc,
    input  logic [1:0]  aluop,
    input  logic [31:0] npc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] sign_ext,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  wb_ctlout,
    output logic        branch,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] EX_MEM_NPC,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2out,
    output logic [4:0]  five_bit_muxout
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(MUL_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_BITS - 1);

    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        wb_ctl_q, wb_ctl_d;
    logic              branch_q, branch_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [4:0]        dest_q, dest_d;

    logic [DATA_W-1:0]        op_b;
    logic signed [DATA_W-1:0] op_a_s;
    logic signed [DATA_W-1:0] op_b_s;
    logic [DATA_W-1:0]        target;
    logic [DATA_W-1:0]        alu_res;
    logic [DATA_W-1:0]        res_sel;
    logic [5:0]               funct;
    logic [4:0]               dest;
    logic                     is_mul;
    logic                     capture;

    always_comb begin
        op_b    = alusrc ? sign_ext : rdata2;
        op_a_s  = $signed(rdata1);
        op_b_s  = $signed(op_b);
        target  = npc + {sign_ext[DATA_W-3:0], 2'b00};
        dest    = regdst ? instr_1511 : instr_2016;
        funct   = sign_ext[5:0];
        is_mul  = (MUL_EN != 0) && (aluop == 2'b10) && (funct == FN_MUL);
        alu_res = rdata1 + op_b;
        case (aluop)
            2'b01: alu_res = rdata1 - op_b;
            2'b10: begin
                case (funct)
                    FN_SUB:  alu_res = rdata1 - op_b;
                    FN_AND:  alu_res = rdata1 & op_b;
                    FN_OR:   alu_res = rdata1 | op_b;
                    FN_SLT:  alu_res = (op_a_s < op_b_s) ? DATA_W'(1) : '0;
                    default: alu_res = rdata1 + op_b;
                endcase
            end
            default: alu_res = rdata1 + op_b;
        endcase
    end

    // Multiply sequencer: IDLE loads operands, BUSY runs one bit per cycle, DONE retires.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        res_sel  = alu_res;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    stall = !flush;
                    if (!flush) begin
                        mcand_d  = rdata1;
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end
                end else begin
                    capture = !flush;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                capture = !flush;
                res_sel = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Held low during reset even if a MUL is sitting on the inputs.
        stall = stall & rst;
    end

    always_comb begin
        wb_ctl_d   = '0;
        branch_d   = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        npc_d      = '0;
        zero_d     = 1'b0;
        alu_d      = '0;
        rdata2_d   = '0;
        dest_d     = '0;
        if (capture) begin
            wb_ctl_d   = wb_ctl;
            branch_d   = m_ctl[2];
            memread_d  = m_ctl[1];
            memwrite_d = m_ctl[0];
            npc_d      = target;
            zero_d     = (res_sel == '0);
            alu_d      = res_sel;
            rdata2_d   = rdata2;
            dest_d     = dest;
        end
    end

    // EX/MEM boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wb_ctl_q   <= '0;
            branch_q   <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            npc_q      <= '0;
            zero_q     <= 1'b0;
            alu_q      <= '0;
            rdata2_q   <= '0;
            dest_q     <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wb_ctl_q   <= wb_ctl_d;
            branch_q   <= branch_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            npc_q      <= npc_d;
            zero_q     <= zero_d;
            alu_q      <= alu_d;
            rdata2_q   <= rdata2_d;
            dest_q     <= dest_d;
        end
    end

    assign wb_ctlout       = wb_ctl_q;
    assign branch          = branch_q;
    assign memread         = memread_q;
    assign memwrite        = memwrite_q;
    assign EX_MEM_NPC      = npc_q;
    assign zero            = zero_q;
    assign alu_result      = alu_q;
    assign rdata2out       = rdata2_q;
    assign five_bit_muxout = dest_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: fixed vector table, randomized ops against a reference model,
// and hand sequences for multiply, flush and asynchronous reset.
module tb_execute_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b2;
        logic [31:0] se;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic        br;
        logic        mr;
        logic        mw;
        logic [31:0] tgt;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] r2;
        logic [4:0]  dest;
    } out_t;

    typedef struct {
        in_t         i;
        logic [31:0] alu;
        logic        z;
        logic [31:0] tgt;
        logic [4:0]  dest;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] sign_ext;
    logic [4:0]  instr_2016;
    logic [4:0]  instr_1511;
    logic        flush;
    logic        stall;
    logic [1:0]  wb_ctlout;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] EX_MEM_NPC;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  five_bit_muxout;

    int checks = 0;
    int errors = 0;

    execute_stage #(.MUL_EN(1), .MUL_BITS(32)) dut (
        .clk(clk), .rst(rst), .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst),
        .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .sign_ext(sign_ext), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .flush(flush), .stall(stall), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC), .zero(zero),
        .alu_result(alu_result), .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the instruction semantics.
    function automatic out_t model(input in_t i);
        out_t        e;
        logic [31:0] b;
        logic [31:0] r;
        logic [63:0] p;
        b = i.alusrc ? i.se : i.b2;
        p = {32'h0, i.a} * {32'h0, b};
        if (i.aluop == 2'b01) begin
            r = i.a - b;
        end else if (i.aluop == 2'b10) begin
            case (i.se[5:0])
                6'h22:   r = i.a - b;
                6'h24:   r = i.a & b;
                6'h25:   r = i.a | b;
                6'h2A:   r = ($signed(i.a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18:   r = p[31:0];
                default: r = i.a + b;
            endcase
        end else begin
            r = i.a + b;
        end
        e.wb   = i.wb;
        e.br   = i.m[2];
        e.mr   = i.m[1];
        e.mw   = i.m[0];
        e.tgt  = i.npc + i.se * 32'd4;
        e.zero = (r == 32'd0);
        e.alu  = r;
        e.r2   = i.b2;
        e.dest = i.regdst ? i.rd : i.rt;
        return e;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.wb   = wb_ctlout;
        o.br   = branch;
        o.mr   = memread;
        o.mw   = memwrite;
        o.tgt  = EX_MEM_NPC;
        o.zero = zero;
        o.alu  = alu_result;
        o.r2   = rdata2out;
        o.dest = five_bit_muxout;
        return o;
    endfunction

    task automatic chk_outs(input string tag, input out_t exp);
        out_t a;
        a = sample();
        chk({tag, "_wb"},   32'(a.wb),   32'(exp.wb));
        chk({tag, "_br"},   32'(a.br),   32'(exp.br));
        chk({tag, "_mr"},   32'(a.mr),   32'(exp.mr));
        chk({tag, "_mw"},   32'(a.mw),   32'(exp.mw));
        chk({tag, "_tgt"},  a.tgt,       exp.tgt);
        chk({tag, "_zero"}, 32'(a.zero), 32'(exp.zero));
        chk({tag, "_alu"},  a.alu,       exp.alu);
        chk({tag, "_r2"},   a.r2,        exp.r2);
        chk({tag, "_dest"}, 32'(a.dest), 32'(exp.dest));
    endtask

    task automatic drive(input in_t i);
        wb_ctl     = i.wb;
        m_ctl      = i.m;
        regdst     = i.regdst;
        alusrc     = i.alusrc;
        aluop      = i.aluop;
        npc        = i.npc;
        rdata1     = i.a;
        rdata2     = i.b2;
        sign_ext   = i.se;
        instr_2016 = i.rt;
        instr_1511 = i.rd;
    endtask

    function automatic in_t mk_mul(input logic [31:0] a, input logic [31:0] b);
        return '{2'b01, 3'b000, 1'b1, 1'b0, 2'b10, 32'h400, a, b, 32'h18, 5'd2, 5'd17};
    endfunction

    function automatic in_t mk_add(input logic [31:0] a, input logic [31:0] b);
        return '{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h80, a, b, 32'h20, 5'd1, 5'd12};
    endfunction

    // Drives a MUL at edge+1 and follows it through to retirement.
    task automatic run_mul(input string tag, input in_t i);
        int hi;
        int bad;
        hi  = 0;
        bad = 0;
        drive(i);
        #1;
        if (stall) hi++;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (stall) hi++;
            if (sample() !== out_t'(0)) bad++;
        end
        chk({tag, "_stall_cycles"}, hi, 33);
        chk({tag, "_bubbles"}, bad, 0);
        @(posedge clk);
        #1;
        chk_outs({tag, "_res"}, model(i));
    endtask

    vec_t vecs[11];
    out_t o;
    in_t  r;

    initial begin
        vecs[0]  = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h40,  32'd5,        32'd7,        32'h20,       5'd3, 5'd9},
                     32'd12, 1'b0, 32'hC0, 5'd9};
        vecs[1]  = '{'{2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'h1234,     32'h1234,     32'd4,        5'd5, 5'd6},
                     32'd0, 1'b1, 32'h110, 5'd5};
        vecs[2]  = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h2A,       5'd3, 5'd4},
                     32'd1, 1'b0, 32'hA8, 5'd4};
        vecs[3]  = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'd1,        32'hFFFFFFFF, 32'h2A,       5'd3, 5'd4},
                     32'd0, 1'b1, 32'hA8, 5'd4};
        vecs[4]  = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'd0,        32'd1,        32'h22,       5'd3, 5'd8},
                     32'hFFFFFFFF, 1'b0, 32'h88, 5'd8};
        vecs[5]  = '{'{2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h24,       5'd3, 5'd10},
                     32'hF000F000, 1'b0, 32'h90, 5'd10};
        vecs[6]  = '{'{2'b11, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'hF0F0F0F0, 32'hFF00FF00, 32'h25,       5'd3, 5'd11},
                     32'hFFF0FFF0, 1'b0, 32'h94, 5'd11};
        vecs[7]  = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'd10,       32'd20,       32'h3F,       5'd3, 5'd13},
                     32'd30, 1'b0, 32'hFC, 5'd13};
        vecs[8]  = '{'{2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h200, 32'h1000,     32'hDEAD,     32'hFFFFFFFC, 5'd7, 5'd1},
                     32'hFFC, 1'b0, 32'h1F0, 5'd7};
        vecs[9]  = '{'{2'b00, 3'b001, 1'b0, 1'b1, 2'b11, 32'h10,  32'hFFFFFFF8, 32'h55,       32'd8,        5'd6, 5'd2},
                     32'd0, 1'b1, 32'h30, 5'd6};
        vecs[10] = '{'{2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0,   32'h7FFFFFFF, 32'd1,        32'h20,       5'd3, 5'd14},
                     32'h80000000, 1'b0, 32'h80, 5'd14};

        rst   = 1'b0;
        flush = 1'b0;
        drive(in_t'(0));
        #12;
        chk_outs("reset", out_t'(0));
        chk("reset_stall", 32'(stall), 0);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].i);
            #1;
            chk($sformatf("vec%0d_stall", v), 32'(stall), 0);
            @(posedge clk);
            #1;
            o      = model(vecs[v].i);
            o.alu  = vecs[v].alu;
            o.zero = vecs[v].z;
            o.tgt  = vecs[v].tgt;
            o.dest = vecs[v].dest;
            chk_outs($sformatf("vec%0d", v), o);
        end

        for (int n = 0; n < 150; n++) begin
            logic fl;
            r.wb     = 2'($urandom);
            r.m      = 3'($urandom);
            r.regdst = 1'($urandom);
            r.alusrc = 1'($urandom);
            r.aluop  = 2'($urandom);
            r.npc    = $urandom;
            r.a      = $urandom;
            r.b2     = $urandom;
            r.se     = $urandom;
            r.rt     = 5'($urandom);
            r.rd     = 5'($urandom);
            case ($urandom_range(0, 5))
                0: r.se[5:0] = 6'h20;
                1: r.se[5:0] = 6'h22;
                2: r.se[5:0] = 6'h24;
                3: r.se[5:0] = 6'h25;
                4: r.se[5:0] = 6'h2A;
                default: ;
            endcase
            if (r.se[5:0] == 6'h18) r.se[5:0] = 6'h20;
            if ($urandom_range(0, 3) == 0) begin
                r.alusrc = 1'b0;
                r.b2     = r.a;
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(r);
            flush = fl;
            #1;
            chk($sformatf("rnd%0d_stall", n), 32'(stall), 0);
            @(posedge clk);
            #1;
            flush = 1'b0;
            chk_outs($sformatf("rnd%0d", n), fl ? out_t'(0) : model(r));
        end

        run_mul("mul7x6", mk_mul(32'd7, 32'd6));
        o = sample();
        chk("mul7x6_const", o.alu, 32'd42);
        run_mul("mul_wrap", mk_mul(32'h10000, 32'h10000));
        o = sample();
        chk("mul_wrap_zero", 32'(o.zero), 1);

        // MUL presented together with flush never starts.
        drive(mk_mul(32'd3, 32'd3));
        flush = 1'b1;
        #1;
        chk("mulflush_idle_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk_outs("mulflush_idle", out_t'(0));

        // Flush while the multiplier is busy.
        drive(mk_mul(32'd7, 32'd6));
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        chk("flushbusy_stall_same", 32'(stall), 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk_outs("flushbusy_bubble", out_t'(0));
        drive(mk_add(32'd40, 32'd2));
        #1;
        chk("flushbusy_stall_next", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk_outs("flushbusy_add", model(mk_add(32'd40, 32'd2)));

        // Asynchronous reset clears held results mid-cycle.
        drive(mk_add(32'd100, 32'd23));
        @(posedge clk);
        #1;
        chk_outs("prereset_add", model(mk_add(32'd100, 32'd23)));
        #3 rst = 1'b0;
        #1;
        chk_outs("async_reset", out_t'(0));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-multiply.
        drive(mk_mul(32'd9, 32'd9));
        repeat (5) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        chk("midmul_reset_stall", 32'(stall), 0);
        chk_outs("midmul_reset", out_t'(0));
        drive(mk_add(32'd1, 32'd2));
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("postreset_add", model(mk_add(32'd1, 32'd2)));

        for (int n = 0; n < 4; n++) begin
            run_mul($sformatf("rmul%0d", n), mk_mul($urandom, $urandom));
        end
        drive(mk_add(32'd5, 32'd5));
        @(posedge clk);
        #1;
        chk_outs("final_add", model(mk_add(32'd5, 32'd5)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
